// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo: write port, FIFO status and serial line.
// The master drives enable and writes; the slave (transmitter) returns status and the tx line.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 enable;
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 full;
    logic                 empty;
    logic [LW-1:0]        level;
    logic                 tx;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output enable, wr_en, wr_data,
        input  full, empty, level, tx, busy, done, error
    );

    modport slave (
        input  enable, wr_en, wr_data,
        output full, empty, level, tx, busy, done, error
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: start bit, LSB-first data, optional parity,
// one or two stop bits; back-to-back frames leave no idle gap on the line.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = 4;
    localparam int SW = DATA_BITS + 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [LW-1:0]        level_q, level_n;
    logic                 full_q, empty_q, error_q;
    logic                 push, pop;

    assign push = bus.wr_en & bus.enable & ~full_q;

    always_comb begin
        level_n = level_q;
        case ({push, pop})
            2'b10:   level_n = level_q + LW'(1);
            2'b01:   level_n = level_q - LW'(1);
            default: level_n = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            error_q <= 1'b0;
        end else if (!bus.enable) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            level_q <= level_n;
            full_q  <= (level_n == LW'(FIFO_DEPTH));
            empty_q <= (level_n == '0);
            if (bus.wr_en && full_q) error_q <= 1'b1;
        end
    end

    // Parity rides as the top bit of the shift register so DATA and PARITY share one shifter.
    function automatic logic par_bit(input logic [DATA_BITS-1:0] w);
        return (PARITY == 2) ? ~^w : ^w;
    endfunction

    logic [DATA_BITS-1:0] head;
    logic [SW-1:0]        frame_word;

    assign head       = mem[rptr];
    assign frame_word = {par_bit(head), head};

    // ---------------- transmit FSM ----------------
    state_t        state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [BW-1:0] bidx, bidx_n;
    logic [SW-1:0] sh, sh_n;
    logic          tx_q, tx_n, busy_q, busy_n, done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            tmr    <= '0;
            bidx   <= '0;
            sh     <= '0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            tmr    <= tmr_n;
            bidx   <= bidx_n;
            sh     <= sh_n;
            tx_q   <= tx_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        tmr_n   = tmr + TW'(1);
        bidx_n  = bidx;
        sh_n    = sh;
        tx_n    = tx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                tmr_n  = '0;
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    sh_n    = frame_word;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (tmr == BIT_LAST) begin
                    tmr_n   = '0;
                    tx_n    = sh[0];
                    sh_n    = sh >> 1;
                    bidx_n  = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tmr == BIT_LAST) begin
                    tmr_n = '0;
                    if (bidx == BIDX_LAST) begin
                        // After DATA_BITS shifts, sh[0] holds the parity bit.
                        if (PARITY != 0) begin
                            tx_n    = sh[0];
                            state_n = ST_PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = ST_STOP;
                        end
                    end else begin
                        tx_n   = sh[0];
                        sh_n   = sh >> 1;
                        bidx_n = bidx + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tmr == BIT_LAST) begin
                    tmr_n   = '0;
                    tx_n    = 1'b1;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tmr == STOP_LAST) begin
                    tmr_n  = '0;
                    done_n = 1'b1;
                    if (!empty_q) begin
                        pop     = 1'b1;
                        sh_n    = frame_word;
                        tx_n    = 1'b0;
                        state_n = ST_START;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                tmr_n   = '0;
            end
        endcase
        // Disable wins over everything: abort the frame and keep the line idle.
        if (!bus.enable) begin
            state_n = ST_IDLE;
            tmr_n   = '0;
            bidx_n  = '0;
            sh_n    = '0;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            pop     = 1'b0;
        end
    end

    assign bus.full  = full_q;
    assign bus.empty = empty_q;
    assign bus.level = level_q;
    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.error = error_q;
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, sets clk cycles per serial bit; legal range is 2 or more.
REQ-002 Parameter DATA_BITS, default 8, sets data bits per frame; legal range is 5..9.
REQ-003 Parameter PARITY, default 1, selects parity: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, sets the number of stop bits; legal values are 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 8, sets transmit FIFO depth; it SHALL be a power of 2, 2 or more.
REQ-006 clk  in  1  single system clock; all logic is rising-edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 enable  in  1  transmitter enable; low flushes the FIFO and idles the line.
REQ-009 wr_en  in  1  single-cycle write strobe into the FIFO.
REQ-010 wr_data  in  DATA_BITS  word to enqueue.
REQ-011 full  out  1  FIFO holds FIFO_DEPTH words.
REQ-012 empty  out  1  FIFO holds 0 words.
REQ-013 level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 tx  out  1  serial line, idle high.
REQ-015 busy  out  1  high while a frame is on the line.
REQ-016 done  out  1  one-cycle pulse at the end of each frame.
REQ-017 error  out  1  sticky overflow flag.

Function
REQ-018 A write SHALL be accepted when wr_en=1, enable=1 and full=0; otherwise the word is dropped.
REQ-019 wr_en=1 while full=1 with enable=1 SHALL drop the word and set error; error stays set until enable=0 or rst.
REQ-020 full, empty and level SHALL be registered and reflect accepted writes and pops from the previous edge.
REQ-021 A simultaneous write and pop SHALL leave level unchanged.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-024 Each state SHALL hold tx constant for CLKS_PER_BIT cycles, counted by a bit-timer.
REQ-025 IDLE with enable=1 and empty=0 SHALL, on the next edge, pop the head word into a shift register, drive tx=0, set busy=1, and enter START.
REQ-026 On START timeout the FSM SHALL enter DATA; data bits are sent LSB first, and tx updates on each bit-timer expiry.
REQ-027 After DATA_BITS data bits the FSM SHALL enter PARITY if PARITY!=0, otherwise STOP.
REQ-028 The PARITY bit SHALL be the XOR of the data bits for even parity and the XNOR for odd parity.
REQ-029 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-030 On the final STOP expiry, done SHALL pulse high for 1 cycle.
REQ-031 On that same expiry, if the FIFO is non-empty, the FSM SHALL pop the next word and enter START, keeping busy=1 and leaving no idle gap; otherwise it SHALL clear busy and enter IDLE.
REQ-032 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles, measured from the tx falling edge to the done pulse.
REQ-033 enable=0 SHALL synchronously abort any frame on the next edge: FSM to IDLE, tx=1, busy=0, done=0, FIFO emptied, error cleared.
REQ-034 An illegal FSM encoding SHALL return the FSM to IDLE with tx=1.

Reset
REQ-035 rst=1 SHALL asynchronously force the FSM to IDLE and set tx=1, busy=0, done=0, error=0, empty=1, full=0 and level=0.
REQ-036 rst=1 SHALL also clear the pointers, the bit-timer, the bit index and the shift register.
REQ-037 rst asserted mid-frame SHALL drive tx=1 immediately, with no partial stop bit.

Verification
REQ-038 Use CLKS_PER_BIT=4, DATA_BITS=8, even parity, 1 stop bit: write 0xA5 -> tx = 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1, each bit held 4 cycles; done pulses 44 cycles after the tx falling edge.
REQ-039 Write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 44-cycle frames with no idle cycles; done pulses 3 times; empty=1 after the third pop.
REQ-040 With enable=1, write on every cycle until full=1, then write once more -> error=1, the extra word is never transmitted, and level=FIFO_DEPTH.
REQ-041 Use DATA_BITS=7, odd parity, 2 stop bits: write 0x7F -> parity bit 0, stop high for 8 cycles, and a frame length of 44 cycles.
REQ-042 Drop enable to 0 in the middle of the DATA state -> on the next edge tx=1, busy=0, empty=1, error=0, and no done pulse.
REQ-043 Assert rst asynchronously between clock edges during START -> tx=1 and level=0 before the next clk edge.
